cpu_instr_sequencer: RTL and testbench

Instruction sequencer that drives the instruction end of `simple_cpu`.
- Holds a small loadable program memory of 20-bit instruction words.
- On `start`, presents each word on `instruction` for a fixed number of clock cycles, so the multi-cycle CPU can complete it.
- Stops at a HALT word or at the end of memory.
- Sits between the program loader (bench or boot logic) and the CPU's `instruction` input; the CPU needs no handshake changes.

---
 rtl/cpu_seq_pkg.sv | 12 +
 rtl/cpu_instr_sequencer_prog_mem.sv | 17 +
 rtl/cpu_instr_sequencer.sv | 96 +++++++++
 tb/tb_cpu_instr_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared constants, instruction fields and FSM state type for the instruction sequencer.
package cpu_seq_pkg;
  localparam logic [19:0] NOP_WORD  = 20'h00000;
  localparam logic [19:0] HALT_WORD = 20'h00001;
  localparam int TYPE_MSB = 19;
  localparam int TYPE_LSB = 18;
  localparam logic [1:0] TYPE_CTRL  = 2'b00;
  localparam logic [1:0] TYPE_ALU   = 2'b01;
  localparam logic [1:0] TYPE_LOAD  = 2'b10;
  localparam logic [1:0] TYPE_STORE = 2'b11;
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} seq_state_t;
endpackage

// File: rtl/cpu_instr_sequencer_prog_mem.sv
// prog_mem: program store with a synchronous write port and a combinational read port, no reset.
module prog_mem #(
  parameter int INSTR_WIDTH    = 20,
  parameter int PROG_ADDR_BITS = 5
) (
  input  logic                      clk,
  input  logic                      i_we,
  input  logic [PROG_ADDR_BITS-1:0] i_waddr,
  input  logic [INSTR_WIDTH-1:0]    i_wdata,
  input  logic [PROG_ADDR_BITS-1:0] i_raddr,
  output logic [INSTR_WIDTH-1:0]    o_rdata
);
  logic [INSTR_WIDTH-1:0] r_mem [2**PROG_ADDR_BITS];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/cpu_instr_sequencer.sv
// cpu_instr_sequencer: issues stored program words to the CPU, holding each for HOLD_CYCLES edges until HALT or end of memory.
module cpu_instr_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int INSTR_WIDTH    = 20,
  parameter int PROG_ADDR_BITS = 5,
  parameter int HOLD_CYCLES    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_en,
  input  logic [PROG_ADDR_BITS-1:0] load_addr,
  input  logic [INSTR_WIDTH-1:0]    load_data,
  input  logic                      start,
  output logic [INSTR_WIDTH-1:0]    instruction,
  output logic                      instr_valid,
  output logic [PROG_ADDR_BITS-1:0] pc,
  output logic                      busy,
  output logic                      done
);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [PROG_ADDR_BITS-1:0] LAST_ADDR = '1;

  seq_state_t                r_state, w_next_state;
  logic [PROG_ADDR_BITS-1:0] r_pc, w_next_pc, w_rd_addr;
  logic [HW-1:0]             r_hold, w_next_hold;
  logic [INSTR_WIDTH-1:0]    r_instr, w_next_instr, w_rd_data;
  logic                      r_valid, w_next_valid, r_busy, r_done, w_halt;

  // Start decisions look at word 0; during issue we look ahead at the next word.
  assign w_rd_addr = (r_state == ISSUE) ? r_pc + 1'b1 : '0;
  assign w_halt    = (w_rd_data == INSTR_WIDTH'(HALT_WORD));

  prog_mem #(.INSTR_WIDTH(INSTR_WIDTH), .PROG_ADDR_BITS(PROG_ADDR_BITS)) u_mem (
    .clk     (clk),
    .i_we    (load_en && r_state != ISSUE),
    .i_waddr (load_addr),
    .i_wdata (load_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_hold  <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_hold  <= w_next_hold;
      r_instr <= w_next_instr;
      r_valid <= w_next_valid;
      r_busy  <= (w_next_state == ISSUE);
      r_done  <= (w_next_state == DONE);
    end

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_hold  = r_hold;
    w_next_instr = r_instr;
    w_next_valid = r_valid;
    if (r_state == ISSUE) begin
      if (r_hold != '0) w_next_hold = r_hold - 1'b1;
      else if (r_pc == LAST_ADDR || w_halt) begin
        w_next_state = DONE;
        w_next_instr = '0;
        w_next_valid = 1'b0;
      end else begin
        w_next_pc    = r_pc + 1'b1;
        w_next_instr = w_rd_data;
        w_next_hold  = HOLD_LAST;
      end
    end else if (start) begin
      w_next_state = w_halt ? DONE : ISSUE;
      w_next_instr = w_halt ? '0 : w_rd_data;
      w_next_valid = !w_halt;
      w_next_pc    = w_halt ? r_pc : '0;
      w_next_hold  = w_halt ? r_hold : HOLD_LAST;
    end
  end

  always_comb begin
    instruction = r_instr;
    instr_valid = r_valid;
    pc          = r_pc;
    busy        = r_busy;
    done        = r_done;
  end
endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// tb_cpu_instr_sequencer: scoreboard bench; a behavioural program model predicts every cycle of each run.
module tb_cpu_instr_sequencer;
  localparam logic [19:0] HALT = 20'h00001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_en = 1'b0;
  logic [4:0]  load_addr = '0;
  logic [19:0] load_data = '0;
  logic        start = 1'b0;
  logic [19:0] instruction;
  logic        instr_valid;
  logic [4:0]  pc;
  logic        busy;
  logic        done;

  cpu_instr_sequencer #(.INSTR_WIDTH(20), .PROG_ADDR_BITS(5), .HOLD_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  wire [27:0] w_obs = {instruction, instr_valid, pc, busy, done};

  logic [19:0] mm [32];
  logic [27:0] q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic push(input logic [19:0] i, input logic v, input logic [4:0] p, input logic b, input logic d);
    q.push_back({i, v, p, b, d});
  endtask

  // Expected cycle-by-cycle trace of one run of the modelled program, ending with one DONE cycle.
  task automatic push_run();
    int a;
    for (a = 0; a < 32 && mm[a] != HALT; a++)
      repeat (4) push(mm[a], 1'b1, 5'(a), 1'b1, 1'b0);
    push(20'h0, 1'b0, (a == 0) ? 5'd0 : 5'(a - 1), 1'b0, 1'b1);
  endtask

  task automatic load_word(input logic [4:0] a, input logic [19:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    mm[a] = d;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_prog3();
    load_word(0, 20'h47000);
    load_word(1, 20'h53000);
    load_word(2, 20'h72001);
    load_word(3, HALT);
  endtask

  task automatic test_reset();
    logic [27:0] e;
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (w_obs !== 28'h0) begin
      miscompares++;
      $display("FAIL reset_assert: got %h want %h", w_obs, 28'h0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) push(20'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      vectors++;
      if (w_obs !== e) begin
        miscompares++;
        $display("FAIL reset_idle: got %h want %h", w_obs, e);
      end
    end
  endtask

  task automatic test_normal_run();
    logic [27:0] e;
    int c = 0;
    load_prog3();
    push_run();
    pulse_start();
    while (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (w_obs !== e) begin
        miscompares++;
        $display("FAIL normal_run cyc %0d: got %h want %h", c, w_obs, e);
      end
      c++;
      if (q.size() > 0) @(negedge clk);
    end
  endtask

  task automatic test_restart();
    logic [27:0] e;
    int c = 0;
    push_run();
    pulse_start();
    while (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (w_obs !== e) begin
        miscompares++;
        $display("FAIL restart cyc %0d: got %h want %h", c, w_obs, e);
      end
      c++;
      if (q.size() > 0) @(negedge clk);
    end
  endtask

  task automatic test_load_during_issue();
    logic [27:0] e;
    int c = 0;
    push_run();
    pulse_start();
    while (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (w_obs !== e) begin
        miscompares++;
        $display("FAIL load_during_issue cyc %0d: got %h want %h", c, w_obs, e);
      end
      if (c == 1) begin
        load_en = 1'b1; load_addr = 5'd1; load_data = 20'h72001;
      end else load_en = 1'b0;
      c++;
      if (q.size() > 0) @(negedge clk);
    end
    load_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [27:0] e;
    int c = 0;
    push_run();
    pulse_start();
    while (c < 6) begin
      e = q.pop_front();
      vectors++;
      if (w_obs !== e) begin
        miscompares++;
        $display("FAIL reset_mid_pre cyc %0d: got %h want %h", c, w_obs, e);
      end
      c++;
      @(negedge clk);
    end
    q.delete();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (w_obs !== 28'h0) begin
      miscompares++;
      $display("FAIL reset_mid_async: got %h want %h", w_obs, 28'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) push(20'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      vectors++;
      if (w_obs !== e) begin
        miscompares++;
        $display("FAIL reset_mid_idle: got %h want %h", w_obs, e);
      end
    end
    c = 0;
    push_run();
    pulse_start();
    while (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (w_obs !== e) begin
        miscompares++;
        $display("FAIL reset_mem_kept cyc %0d: got %h want %h", c, w_obs, e);
      end
      c++;
      if (q.size() > 0) @(negedge clk);
    end
  endtask

  task automatic test_halt_at_zero();
    logic [27:0] e;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    load_word(0, HALT);
    push_run();
    repeat (2) push(20'h0, 1'b0, 5'd0, 1'b0, 1'b1);
    pulse_start();
    while (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (w_obs !== e) begin
        miscompares++;
        $display("FAIL halt_at_zero: got %h want %h", w_obs, e);
      end
      if (q.size() > 0) @(negedge clk);
    end
  endtask

  task automatic test_full_memory();
    logic [27:0] e;
    int c = 0;
    for (int i = 0; i < 32; i++) load_word(5'(i), 20'hD80F0 + 20'(i));
    push_run();
    pulse_start();
    while (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (w_obs !== e) begin
        miscompares++;
        $display("FAIL full_memory cyc %0d: got %h want %h", c, w_obs, e);
      end
      c++;
      if (q.size() > 0) @(negedge clk);
    end
  endtask

  task automatic test_load_start_same_edge();
    logic [27:0] e;
    int c = 0;
    push_run();
    @(negedge clk);
    start = 1'b1; load_en = 1'b1; load_addr = 5'd0; load_data = HALT;
    @(negedge clk);
    start = 1'b0; load_en = 1'b0;
    mm[0] = HALT;
    while (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (w_obs !== e) begin
        miscompares++;
        $display("FAIL load_start_same_edge cyc %0d: got %h want %h", c, w_obs, e);
      end
      c++;
      if (q.size() > 0) @(negedge clk);
    end
    push(20'h0, 1'b0, 5'd31, 1'b0, 1'b1);
    @(negedge clk);
    e = q.pop_front();
    vectors++;
    if (w_obs !== e) begin
      miscompares++;
      $display("FAIL load_start_done_hold: got %h want %h", w_obs, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_normal_run();
    test_restart();
    test_load_during_issue();
    test_reset_mid();
    test_halt_at_zero();
    test_full_memory();
    test_load_start_same_edge();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
